// File: rtl/uc_pkg.sv
// Shared constants and types for the parametrised control unit (uc_param)
// and its return-address stack (uc_pila).
package uc_pkg;

  // opcode[3] selects the instruction class; opcode[2:0] selects the control op
  localparam logic       OPC_CLASS_ALU  = 1'b0;
  localparam logic       OPC_CLASS_CTRL = 1'b1;

  localparam logic [2:0] OPC_LOAD = 3'b000;
  localparam logic [2:0] OPC_JMP  = 3'b001;
  localparam logic [2:0] OPC_JZ   = 3'b010;
  localparam logic [2:0] OPC_JNZ  = 3'b011;
  localparam logic [2:0] OPC_JREL = 3'b100;
  localparam logic [2:0] OPC_CALL = 3'b101;
  localparam logic [2:0] OPC_RET  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] PCS_INC = 2'b00;
  localparam logic [1:0] PCS_ABS = 2'b01;
  localparam logic [1:0] PCS_REL = 2'b10;
  localparam logic [1:0] PCS_RET = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/uc_pila.sv
// Return-address LIFO for uc_param: DEPTH entries of W bits.
// Built only when UC_STACK_EN is defined.
`ifdef UC_STACK_EN
module uc_pila #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0] r_sp;
  logic [W-1:0]   r_mem [DEPTH];
  logic [SPW-1:0] w_sp_dec;

  assign w_sp_dec = r_sp - SPW'(1);
  assign full     = (r_sp == SPW'(DEPTH));
  assign empty    = (r_sp == '0);
  assign top      = empty ? '0 : r_mem[AW'(w_sp_dec)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_sp <= r_sp + SPW'(1);
    end else if (pop && !empty) begin
      r_sp <= w_sp_dec;
    end
  end

  // NOTE: entries carry no reset; r_sp alone decides which slots are valid,
  // so the array can map to plain storage without a reset network.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[AW'(r_sp)] <= din;
    end
  end

endmodule
`endif

// File: rtl/uc_param.sv
// Parametrised single-cycle CPU control unit: opcode decode, registered zero
// flag, RUN/HALT FSM. CALL/RET and the return stack exist only under UC_STACK_EN.
module uc_param
  import uc_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int ALUOPW      = 3,
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              z,
  input  logic [PCW-1:0]    pc_cur,
  output logic [ALUOPW-1:0] op,
  output logic              we3,
  output logic              s_inm,
  output logic [1:0]        pc_sel,
  output logic              s_inc,
  output logic              pc_en,
  output logic [PCW-1:0]    pc_ret,
  output logic              fin,
  output logic              stack_err
);

  state_t     r_state;
  logic       r_zflag;
  logic       w_zflag_ld;
  logic       w_halt_req;
  logic       w_err;
  logic [2:0] w_sub;
  logic       w_unused_opc;

  assign w_sub        = opcode[2:0];
  assign w_unused_opc = ^opcode;
  assign op           = opcode[ALUOPW-1:0];
  assign s_inc        = (pc_sel == PCS_INC);
  assign fin          = (r_state == ST_HALT);

`ifdef UC_STACK_EN
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [PCW-1:0] w_top;
  logic [PCW-1:0] w_ret_addr;
  logic           r_stack_err;

  assign w_ret_addr = pc_cur + PCW'(1);
  assign pc_ret     = w_top;
  assign stack_err  = r_stack_err;

  uc_pila #(
    .DEPTH (STACK_DEPTH),
    .W     (PCW)
  ) u_pila (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_ret_addr),
    .top   (w_top),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stack_err <= 1'b0;
    end else if (w_err) begin
      r_stack_err <= 1'b1;
    end
  end
`else
  logic w_unused_pc;

  assign w_unused_pc = ^pc_cur;
  assign pc_ret      = '0;
  assign stack_err   = 1'b0;
`endif

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    we3        = 1'b0;
    s_inm      = 1'b0;
    pc_sel     = PCS_INC;
    pc_en      = 1'b0;
    w_zflag_ld = 1'b0;
    w_halt_req = 1'b0;
    w_err      = 1'b0;
`ifdef UC_STACK_EN
    w_push     = 1'b0;
    w_pop      = 1'b0;
`endif
    // Reset low or HALT: everything stays at the quiet defaults
    if (reset && (r_state == ST_RUN)) begin
      pc_en = 1'b1;
      if (opcode[3] == OPC_CLASS_ALU) begin
        we3        = 1'b1;
        w_zflag_ld = 1'b1;
      end else begin
        case (w_sub)
          OPC_LOAD: begin
            we3   = 1'b1;
            s_inm = 1'b1;
          end
          OPC_JMP:  pc_sel = PCS_ABS;
          OPC_JZ:   pc_sel = r_zflag ? PCS_ABS : PCS_INC;
          OPC_JNZ:  pc_sel = r_zflag ? PCS_INC : PCS_ABS;
          OPC_JREL: pc_sel = PCS_REL;
`ifdef UC_STACK_EN
          OPC_CALL: begin
            if (w_full) begin
              w_err = 1'b1;
              pc_en = 1'b0;
            end else begin
              w_push = 1'b1;
              pc_sel = PCS_ABS;
            end
          end
          OPC_RET: begin
            if (w_empty) begin
              w_err = 1'b1;
              pc_en = 1'b0;
            end else begin
              w_pop  = 1'b1;
              pc_sel = PCS_RET;
            end
          end
`endif
          OPC_HALT: begin
            pc_en      = 1'b0;
            w_halt_req = 1'b1;
          end
          default: ;  // CALL/RET without the stack act as NOP
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_zflag <= 1'b0;
    end else begin
      if (w_zflag_ld) begin
        r_zflag <= z;
      end
      if (w_halt_req || w_err) begin
        r_state <= ST_HALT;
      end
    end
  end

endmodule

// File: tb/tb_uc_param.sv
// Self-checking bench for uc_param: directed scenarios plus a random stream,
// all checked against a queue-based reference model. Honours UC_STACK_EN.
module tb_uc_param;

  localparam int OPW    = 6;
  localparam int ALUOPW = 3;
  localparam int PCW    = 10;
  localparam int DEPTH  = 4;
`ifdef UC_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  localparam logic [OPW-1:0] O_ALU  = 6'b000_010;
  localparam logic [OPW-1:0] O_LOAD = 6'b001_000;
  localparam logic [OPW-1:0] O_JMP  = 6'b001_001;
  localparam logic [OPW-1:0] O_JZ   = 6'b001_010;
  localparam logic [OPW-1:0] O_JNZ  = 6'b001_011;
  localparam logic [OPW-1:0] O_CALL = 6'b001_101;
  localparam logic [OPW-1:0] O_RET  = 6'b001_110;
  localparam logic [OPW-1:0] O_HALT = 6'b001_111;

  logic              clk = 1'b0;
  logic              reset;
  logic [OPW-1:0]    opcode;
  logic              z;
  logic [PCW-1:0]    pc_cur;
  logic [ALUOPW-1:0] op;
  logic              we3, s_inm, s_inc, pc_en, fin, stack_err;
  logic [1:0]        pc_sel;
  logic [PCW-1:0]    pc_ret;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_halt;
  bit m_z;
  bit m_err;
  int m_stk[$];

  always #5 clk = ~clk;

  uc_param #(
    .OPW(OPW), .ALUOPW(ALUOPW), .PCW(PCW), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc_cur(pc_cur),
    .op(op), .we3(we3), .s_inm(s_inm), .pc_sel(pc_sel), .s_inc(s_inc),
    .pc_en(pc_en), .pc_ret(pc_ret), .fin(fin), .stack_err(stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    m_halt = 1'b0;
    m_z    = 1'b0;
    m_err  = 1'b0;
    m_stk.delete();
  endfunction

  // Expected outputs for the coming cycle, from the instruction-set rules
  task automatic model_expect(input logic [OPW-1:0] opc,
                              output logic e_we3, output logic e_inm,
                              output logic [1:0] e_sel, output logic e_en,
                              output logic [PCW-1:0] e_ret);
    int sub = int'(opc[2:0]);
    e_we3 = 0; e_inm = 0; e_sel = 0; e_en = 0;
    e_ret = (m_stk.size() > 0) ? PCW'(m_stk[$]) : '0;
    if (!m_halt) begin
      e_en = 1;
      if (!opc[3]) e_we3 = 1;
      else begin
        case (sub)
          0: begin e_we3 = 1; e_inm = 1; end
          1: e_sel = 2'd1;
          2: e_sel = m_z ? 2'd1 : 2'd0;
          3: e_sel = m_z ? 2'd0 : 2'd1;
          4: e_sel = 2'd2;
          5: if (STK_EN) begin
               if (m_stk.size() == DEPTH) e_en = 0; else e_sel = 2'd1;
             end
          6: if (STK_EN) begin
               if (m_stk.size() == 0) e_en = 0; else e_sel = 2'd3;
             end
          default: e_en = 0;
        endcase
      end
    end
  endtask

  function automatic void model_update(input logic [OPW-1:0] opc, input logic zz,
                                       input logic [PCW-1:0] pc);
    int sub = int'(opc[2:0]);
    if (m_halt) return;
    if (!opc[3]) m_z = zz;
    else if (sub == 7) m_halt = 1;
    else if (STK_EN && sub == 5) begin
      if (m_stk.size() == DEPTH) begin m_err = 1; m_halt = 1; end
      else m_stk.push_back((int'(pc) + 1) % (1 << PCW));
    end else if (STK_EN && sub == 6) begin
      if (m_stk.size() == 0) begin m_err = 1; m_halt = 1; end
      else void'(m_stk.pop_back());
    end
  endfunction

  // Called just after a rising edge; drives one instruction, checks at the
  // falling edge, then advances the model across the next rising edge.
  task automatic step(input string tag, input logic [OPW-1:0] opc, input logic zz,
                      input logic [PCW-1:0] pc);
    logic e_we3, e_inm, e_en;
    logic [1:0] e_sel;
    logic [PCW-1:0] e_ret;
    opcode = opc; z = zz; pc_cur = pc;
    model_expect(opc, e_we3, e_inm, e_sel, e_en, e_ret);
    @(negedge clk);
    check({tag, ".op"},     32'(op),        32'(opc[ALUOPW-1:0]));
    check({tag, ".we3"},    32'(we3),       32'(e_we3));
    check({tag, ".s_inm"},  32'(s_inm),     32'(e_inm));
    check({tag, ".pc_sel"}, 32'(pc_sel),    32'(e_sel));
    check({tag, ".s_inc"},  32'(s_inc),     32'(e_sel == 2'd0));
    check({tag, ".pc_en"},  32'(pc_en),     32'(e_en));
    check({tag, ".pc_ret"}, 32'(pc_ret),    32'(e_ret));
    check({tag, ".fin"},    32'(fin),       32'(m_halt));
    check({tag, ".err"},    32'(stack_err), 32'(m_err));
    @(posedge clk);
    model_update(opc, zz, pc);
    #1;
  endtask

  // Asserts reset between edges and checks the asynchronous effect at once
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, ".rst_fin"},   32'(fin),       32'd0);
    check({tag, ".rst_err"},   32'(stack_err), 32'd0);
    check({tag, ".rst_pc_en"}, 32'(pc_en),     32'd0);
    check({tag, ".rst_we3"},   32'(we3),       32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; opcode = '0; z = 1'b0; pc_cur = '0;
    model_reset();
    do_reset("init");

    // Registered zero flag drives JZ, not the live z
    step("aluz1", O_ALU, 1'b1, 10'd1);
    step("jz_t",  O_JZ,  1'b0, 10'd2);
    step("aluz0", O_ALU, 1'b0, 10'd3);
    step("jz_n",  O_JZ,  1'b1, 10'd4);

    // LOAD leaves the flag alone
    step("alu0",  O_ALU,  1'b0, 10'd5);
    step("load",  O_LOAD, 1'b1, 10'd6);
    step("jnz",   O_JNZ,  1'b1, 10'd7);
    step("jrel",  6'b101_100, 1'b0, 10'd8);

    // Nested calls, then an extra RET that underflows only with the stack
    step("call5",  O_CALL, 1'b0, 10'd5);
    step("call20", O_CALL, 1'b0, 10'd20);
    step("ret21",  O_RET,  1'b0, 10'd30);
    step("ret6",   O_RET,  1'b0, 10'd31);
    step("ret_em", O_RET,  1'b0, 10'd32);
    step("after",  O_ALU,  1'b1, 10'd33);
    do_reset("r1");

    // Overflow: fifth CALL errors; later opcodes have no effect
    for (int i = 0; i < 5; i++) step($sformatf("ovf%0d", i), O_CALL, 1'b0, PCW'(100 + i));
    step("ovf_alu", O_ALU, 1'b1, 10'd200);
    step("ovf_jmp", O_JMP, 1'b0, 10'd201);
    step("ovf_ret", O_RET, 1'b0, 10'd202);
    do_reset("r2");

    // Wrap of the return address, then HALT opcode
    step("callw", O_CALL, 1'b0, 10'h3FF);
    step("retw",  O_RET,  1'b0, 10'd0);
    step("halt",  O_HALT, 1'b0, 10'd1);
    step("h_alu", O_ALU,  1'b0, 10'd2);
    step("h_ld",  O_LOAD, 1'b0, 10'd3);
    do_reset("r3");

    // HALT with two entries on the stack, then reset between edges
    step("c_a",   O_CALL, 1'b0, 10'd40);
    step("c_b",   O_CALL, 1'b0, 10'd50);
    step("halt2", O_HALT, 1'b0, 10'd51);
    step("h2",    O_ALU,  1'b1, 10'd52);
    do_reset("r4");
    step("post",  O_ALU,  1'b1, 10'd60);
    step("post_jz", O_JZ, 1'b0, 10'd61);

    // Random stream; control ops weighted, HALT made rare
    for (int i = 0; i < 400; i++) begin
      logic [OPW-1:0] r_opc;
      r_opc = OPW'($urandom_range(0, 63));
      if (r_opc[3:0] == 4'hF && $urandom_range(0, 3) != 0) r_opc[3] = 1'b0;
      step($sformatf("rnd%0d", i), r_opc, 1'($urandom_range(0, 1)), PCW'($urandom));
      if (m_halt && $urandom_range(0, 3) == 0) do_reset($sformatf("rr%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
